// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
`timescale 1ns/1ps
package rv32_mem_pkg;

    // Load/store width encodings carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_R
    } lsu_state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it.
`timescale 1ns/1ps
module load_align
    import rv32_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] formatted
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select and sign/zero extension by access width
    always_comb begin
        byte_lane = rdata[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        formatted = rdata;
        case (funct3)
            F3_B:    formatted = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_BU:   formatted = {{(XLEN-8){1'b0}}, byte_lane};
            F3_H:    formatted = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_HU:   formatted = {{(XLEN-16){1'b0}}, half_lane};
            default: formatted = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory requests, waits for read
// data, stalls the upstream pipeline, and drives the MEM/WB register.
`timescale 1ns/1ps
module mem_stage_lsu
    import rv32_mem_pkg::*;
#(
    parameter int XLEN                    = 32,
    parameter int ALLOW_SAME_CYCLE_RVALID = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ex_ALU,
    input  logic [XLEN-1:0] ex_Data_out2,
    input  logic            ex_MemRead,
    input  logic            ex_MemWrite,
    input  logic [1:0]      ex_MemtoReg,
    input  logic            ex_RegWrite,
    input  logic [XLEN-1:0] ex_PC,
    input  logic [31:0]     ex_Instruction,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] wb_ALU,
    output logic [XLEN-1:0] wb_load_data,
    output logic [XLEN-1:0] wb_PC,
    output logic [31:0]     wb_Instruction,
    output logic [1:0]      wb_MemtoReg,
    output logic            wb_RegWrite
);

    localparam bit SAME_CYCLE = (ALLOW_SAME_CYCLE_RVALID != 0);

    lsu_state_t      state;
    lsu_state_t      state_next;
    logic [2:0]      funct3;
    logic            access;
    logic            illegal;
    logic            legal_access;
    logic            same_cycle_data;
    logic [XLEN-1:0] load_data;

    assign funct3 = ex_Instruction[14:12];
    assign access = ex_MemRead | ex_MemWrite;

    // Classify the access: bad width encodings, conflicting flags, misalignment
    always_comb begin
        illegal = 1'b0;
        if (ex_MemRead && ex_MemWrite) begin
            illegal = 1'b1;
        end else if (ex_MemRead) begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                        funct3 == F3_BU || funct3 == F3_HU);
        end else if (ex_MemWrite) begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end
        if (access && funct3[1:0] == 2'b01 && ex_ALU[0]) begin
            illegal = 1'b1;
        end
        if (access && funct3[1:0] == 2'b10 && ex_ALU[1:0] != 2'b00) begin
            illegal = 1'b1;
        end
    end

    assign legal_access    = access & ~illegal;
    assign same_cycle_data = SAME_CYCLE & mem_gnt & mem_rvalid;

    // Byte enables and lane-replicated store data
    always_comb begin
        mem_addr  = {ex_ALU[XLEN-1:2], 2'b00};
        case (funct3[1:0])
            2'b00: begin
                mem_be    = 4'b0001 << ex_ALU[1:0];
                mem_wdata = {(XLEN/8){ex_Data_out2[7:0]}};
            end
            2'b01: begin
                mem_be    = 4'b0011 << ex_ALU[1:0];
                mem_wdata = {(XLEN/16){ex_Data_out2[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = ex_Data_out2;
            end
        endcase
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata     (mem_rdata),
        .addr      (ex_ALU[1:0]),
        .funct3    (funct3),
        .formatted (load_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a granted load waits for its data unless it already arrived
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (legal_access && ex_MemRead && mem_gnt && !same_cycle_data) begin
                    state_next = WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs and pipeline stall
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        case (state)
            IDLE: begin
                mem_req    = reset & legal_access;
                mem_we     = ex_MemWrite;
                misalign_o = reset & access & illegal;
                if (legal_access) begin
                    if (!mem_gnt) begin
                        stall_o = 1'b1;
                    end else if (ex_MemRead) begin
                        stall_o = !same_cycle_data;
                    end
                end
            end
            WAIT_R: begin
                stall_o = !mem_rvalid;
            end
            default: ;
        endcase
    end

    // MEM/WB register; a stalled cycle becomes a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_ALU         <= '0;
            wb_load_data   <= '0;
            wb_PC          <= '0;
            wb_Instruction <= '0;
            wb_MemtoReg    <= '0;
            wb_RegWrite    <= 1'b0;
        end else if (!stall_o) begin
            wb_ALU         <= ex_ALU;
            wb_load_data   <= load_data;
            wb_PC          <= ex_PC;
            wb_Instruction <= ex_Instruction;
            wb_MemtoReg    <= ex_MemtoReg;
            wb_RegWrite    <= ex_RegWrite & ~(access & illegal);
        end else begin
            wb_RegWrite    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever wb_RegWrite is presented.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ex_ALU, ex_Data_out2, ex_PC, ex_Instruction;
    logic        ex_MemRead, ex_MemWrite, ex_RegWrite;
    logic [1:0]  ex_MemtoReg;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_o, misalign_o;
    logic [31:0] wb_ALU, wb_load_data, wb_PC, wb_Instruction;
    logic [1:0]  wb_MemtoReg;
    logic        wb_RegWrite;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] ld;
        logic [1:0]  m2r;
        bit          chk_ld;
    } exp_t;
    exp_t sb_q[$];

    mem_stage_lsu #(
        .XLEN(32),
        .ALLOW_SAME_CYCLE_RVALID(0)
    ) dut (
        .clk(clk), .reset(reset),
        .ex_ALU(ex_ALU), .ex_Data_out2(ex_Data_out2),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
        .ex_PC(ex_PC), .ex_Instruction(ex_Instruction),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_o(stall_o), .misalign_o(misalign_o),
        .wb_ALU(wb_ALU), .wb_load_data(wb_load_data), .wb_PC(wb_PC),
        .wb_Instruction(wb_Instruction), .wb_MemtoReg(wb_MemtoReg),
        .wb_RegWrite(wb_RegWrite)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every presented writeback must match the oldest expectation
    always @(negedge clk) begin
        if (reset === 1'b1 && wb_RegWrite !== 1'b0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: actual wb_RegWrite=%b wb_ALU=0x%08h expected no writeback",
                         wb_RegWrite, wb_ALU);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wb_ALU", wb_ALU, e.alu);
                check("wb_PC", wb_PC, e.pc);
                check("wb_MemtoReg", {30'd0, wb_MemtoReg}, {30'd0, e.m2r});
                if (e.chk_ld) check("wb_load_data", wb_load_data, e.ld);
            end
        end
    end

    task automatic set_idle();
        ex_ALU = '0; ex_Data_out2 = '0; ex_PC = '0; ex_Instruction = '0;
        ex_MemRead = 1'b0; ex_MemWrite = 1'b0; ex_RegWrite = 1'b0; ex_MemtoReg = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_nonmem(input logic [31:0] alu, input logic [31:0] pc);
        exp_t e;
        cyc(); set_idle();
        ex_ALU = alu; ex_PC = pc; ex_RegWrite = 1'b1; ex_MemtoReg = 2'b00;
        ex_Instruction = 32'h0000_0013;
        e.alu = alu; e.pc = pc; e.ld = '0; e.m2r = 2'b00; e.chk_ld = 1'b0;
        sb_q.push_back(e);
        mid();
        check("nonmem_req", {31'd0, mem_req}, 32'd0);
        check("nonmem_stall", {31'd0, stall_o}, 32'd0);
        cyc(); set_idle();
        mid();
        check("nonmem_req_after", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rs2,
                            input int gnt_delay, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        cyc(); set_idle();
        ex_ALU = addr; ex_Data_out2 = rs2; ex_MemWrite = 1'b1; ex_PC = 32'h0000_0300;
        ex_Instruction = {17'd0, f3, 5'd0, 7'h23};
        for (int i = 0; i <= gnt_delay; i++) begin
            mem_gnt = (i == gnt_delay);
            mid();
            check("st_req", {31'd0, mem_req}, 32'd1);
            check("st_we", {31'd0, mem_we}, 32'd1);
            check("st_be", {28'd0, mem_be}, {28'd0, exp_be});
            check("st_wdata", mem_wdata, exp_wdata);
            check("st_addr", mem_addr, {addr[31:2], 2'b00});
            check("st_stall", {31'd0, stall_o}, (i == gnt_delay) ? 32'd0 : 32'd1);
            if (i < gnt_delay) cyc();
        end
        cyc(); set_idle();
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                           input int gnt_delay, input int rv_delay, input logic [31:0] exp_data,
                           input logic [31:0] pc);
        exp_t e;
        cyc(); set_idle();
        ex_ALU = addr; ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_MemtoReg = 2'b01; ex_PC = pc;
        ex_Instruction = {17'd0, f3, 5'd0, 7'h03};
        e.alu = addr; e.pc = pc; e.ld = exp_data; e.m2r = 2'b01; e.chk_ld = 1'b1;
        sb_q.push_back(e);
        for (int i = 0; i <= gnt_delay; i++) begin
            mem_gnt = (i == gnt_delay);
            mid();
            check("ld_req", {31'd0, mem_req}, 32'd1);
            check("ld_we", {31'd0, mem_we}, 32'd0);
            check("ld_addr", mem_addr, {addr[31:2], 2'b00});
            check("ld_stall_req", {31'd0, stall_o}, 32'd1);
            cyc();
        end
        mem_gnt = 1'b0;
        for (int i = 1; i <= rv_delay; i++) begin
            mem_rvalid = (i == rv_delay);
            mem_rdata  = (i == rv_delay) ? rdata : 32'h5A5A_5A5A;
            mid();
            check("ld_req_wait", {31'd0, mem_req}, 32'd0);
            check("ld_stall_wait", {31'd0, stall_o}, (i == rv_delay) ? 32'd0 : 32'd1);
            if (i < rv_delay) cyc();
        end
        cyc(); set_idle();
    endtask

    task automatic do_illegal(input logic [31:0] addr, input logic rd, input logic wr, input logic [2:0] f3);
        cyc(); set_idle();
        ex_ALU = addr; ex_MemRead = rd; ex_MemWrite = wr; ex_RegWrite = 1'b1;
        ex_Data_out2 = 32'h1111_2222; ex_PC = 32'h0000_0400;
        ex_Instruction = {17'd0, f3, 5'd0, 7'h03};
        mem_gnt = 1'b1;
        mid();
        check("ill_misalign", {31'd0, misalign_o}, 32'd1);
        check("ill_req", {31'd0, mem_req}, 32'd0);
        check("ill_stall", {31'd0, stall_o}, 32'd0);
        cyc(); set_idle();
        mid();
        check("ill_pulse_end", {31'd0, misalign_o}, 32'd0);
        check("ill_wb_regwrite", {31'd0, wb_RegWrite}, 32'd0);
        check("ill_wb_alu", wb_ALU, addr);
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        mid();
        check("rst_wb_ALU", wb_ALU, 32'd0);
        check("rst_wb_load_data", wb_load_data, 32'd0);
        check("rst_wb_PC", wb_PC, 32'd0);
        check("rst_wb_Instruction", wb_Instruction, 32'd0);
        check("rst_wb_MemtoReg", {30'd0, wb_MemtoReg}, 32'd0);
        check("rst_wb_RegWrite", {31'd0, wb_RegWrite}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        reset = 1'b1;

        do_nonmem(32'h0000_1234, 32'h0000_0100);

        do_store(32'h0000_1003, 3'b000, 32'hAABB_CCDD, 0, 4'b1000, 32'hDDDD_DDDD);
        do_store(32'h0000_1002, 3'b001, 32'h1234_ABCD, 1, 4'b1100, 32'hABCD_ABCD);
        do_store(32'h0000_1004, 3'b010, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D);

        do_load(32'h0000_2001, 3'b000, 32'h0000_8000, 2, 3, 32'hFFFF_FF80, 32'h0000_0200);
        do_load(32'h0000_2002, 3'b101, 32'hBEEF_0000, 0, 1, 32'h0000_BEEF, 32'h0000_0204);
        do_load(32'h0000_2002, 3'b001, 32'h8001_0000, 1, 2, 32'hFFFF_8001, 32'h0000_0208);
        do_load(32'h0000_2003, 3'b100, 32'h9F00_0000, 0, 1, 32'h0000_009F, 32'h0000_020C);
        do_load(32'h0000_3000, 3'b010, 32'h1234_5678, 0, 1, 32'h1234_5678, 32'h0000_0210);

        do_illegal(32'h0000_3002, 1'b1, 1'b0, 3'b010);
        do_illegal(32'h0000_2001, 1'b1, 1'b0, 3'b001);
        do_illegal(32'h0000_1000, 1'b1, 1'b1, 3'b010);
        do_illegal(32'h0000_1000, 1'b0, 1'b1, 3'b100);
        do_illegal(32'h0000_1000, 1'b1, 1'b0, 3'b011);

        // Reset while waiting for read data; the late response must be dropped
        cyc(); set_idle();
        ex_ALU = 32'h0000_4000; ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_PC = 32'h0000_0500;
        ex_Instruction = {17'd0, 3'b010, 5'd0, 7'h03};
        mem_gnt = 1'b1;
        mid();
        check("rw_req", {31'd0, mem_req}, 32'd1);
        check("rw_stall", {31'd0, stall_o}, 32'd1);
        cyc(); set_idle();
        mid();
        check("rw_wait_stall", {31'd0, stall_o}, 32'd1);
        check("rw_wait_req", {31'd0, mem_req}, 32'd0);
        reset = 1'b0;
        cyc();
        mid();
        check("rw_rst_wb_ALU", wb_ALU, 32'd0);
        check("rw_rst_wb_load_data", wb_load_data, 32'd0);
        check("rw_rst_stall", {31'd0, stall_o}, 32'd0);
        reset = 1'b1;
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BE00;
        mid();
        check("rw_late_stall", {31'd0, stall_o}, 32'd0);
        check("rw_late_req", {31'd0, mem_req}, 32'd0);
        cyc(); set_idle();
        mid();
        check("rw_after_regwrite", {31'd0, wb_RegWrite}, 32'd0);
        check("rw_after_load_data", wb_load_data, 32'd0);
        check("rw_after_alu", wb_ALU, 32'd0);
        check("rw_after_stall", {31'd0, stall_o}, 32'd0);

        do_nonmem(32'h0000_5678, 32'h0000_0600);

        repeat (3) cyc();
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
